// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in parallel-out deserializer.
// Also used by the transmitter-side bench for its default word width.
package sipo_pkg;

  typedef enum logic {ST_DATA, ST_PAR} sipo_state_e;

  localparam int SIPO_WIDTH_DEF = 4;

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input and parallel valid/ready output bundle of the deserializer.
// par_err exists only when SIPO_PARITY_EN is defined.
interface sipo_deser_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
);
  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
`ifdef SIPO_PARITY_EN
  logic             par_err;

  modport master (
    input  sin, sin_valid, dout_ready,
    output dout, dout_valid, overrun, par_err
  );

  modport slave (
    output sin, sin_valid, dout_ready,
    input  dout, dout_valid, overrun, par_err
  );
`else
  modport master (
    input  sin, sin_valid, dout_ready,
    output dout, dout_valid, overrun
  );

  modport slave (
    output sin, sin_valid, dout_ready,
    input  dout, dout_valid, overrun
  );
`endif
endinterface

// File: rtl/sipo_out_reg.sv
// Output holding register: loads completed words, valid/ready handoff and overrun pulse.
// The par_err flag is present only when SIPO_PARITY_EN is defined.
module sipo_out_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
`ifdef SIPO_PARITY_EN
  input  logic             i_par_err,
  output logic             o_par_err,
`endif
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;
  logic             w_full;

  // A word can be accepted if the slot is empty or is being consumed this edge.
  assign w_full = r_valid && !i_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_load && !w_full) begin
        r_dout  <= i_word;
        r_valid <= 1'b1;
      end else if (i_load) begin
        r_overrun <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic r_par_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_par_err <= 1'b0;
    end else if (i_load && !w_full) begin
      r_par_err <= i_par_err;
    end
  end

  assign o_par_err = r_par_err;
`endif

  assign o_dout    = r_dout;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer, MSB first, with a valid/ready output register.
// Define SIPO_PARITY_EN to add an even-parity bit per frame and the par_err flag.
//
// state   | meaning
// ST_DATA | shifting in data bits; frame ends here when parity is disabled
// ST_PAR  | waiting for the parity bit of a fully shifted word
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic         i_clk,
  input  logic         i_reset,
  sipo_deser_if.master bus
);

  localparam int CW = $clog2(WIDTH + 1);

  sipo_state_e      r_state;
  sipo_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_bitcnt;
  logic [CW-1:0]    w_bitcnt_nxt;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;
`ifdef SIPO_PARITY_EN
  logic             w_par_err;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_DATA;
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_complete   = 1'b0;
    w_word       = r_shreg;
`ifdef SIPO_PARITY_EN
    w_par_err    = 1'b0;
`endif
    case (r_state)
      ST_DATA: begin
        if (bus.sin_valid) begin
          w_shreg_nxt = {r_shreg[WIDTH-2:0], bus.sin};
          if (r_bitcnt == CW'(WIDTH - 1)) begin
            w_bitcnt_nxt = '0;
`ifdef SIPO_PARITY_EN
            w_state_nxt  = ST_PAR;
`else
            w_complete   = 1'b1;
            w_word       = w_shreg_nxt;
`endif
          end else begin
            w_bitcnt_nxt = r_bitcnt + CW'(1);
          end
        end
      end
      ST_PAR: begin
        // The full data word is already parked in the shift register.
        if (bus.sin_valid) begin
          w_complete  = 1'b1;
          w_word      = r_shreg;
          w_state_nxt = ST_DATA;
`ifdef SIPO_PARITY_EN
          w_par_err   = (^r_shreg) ^ bus.sin;
`endif
        end
      end
      default: w_state_nxt = ST_DATA;
    endcase
  end

  sipo_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_complete),
    .i_word    (w_word),
`ifdef SIPO_PARITY_EN
    .i_par_err (w_par_err),
    .o_par_err (bus.par_err),
`endif
    .i_ready   (bus.dout_ready),
    .o_dout    (bus.dout),
    .o_valid   (bus.dout_valid),
    .o_overrun (bus.overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed scenarios plus random traffic against a frame-level model.
// Honours SIPO_PARITY_EN the same way as the design.
module tb_sipo_deser;
  import sipo_pkg::*;

  localparam int W = SIPO_WIDTH_DEF;
`ifdef SIPO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk_sys;
  logic rst;
  int   n_checks;
  int   n_pass;

  sipo_deser_if #(.WIDTH(W)) bus ();

  sipo_deser #(.WIDTH(W)) dut (
    .i_clk   (clk_sys),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // reference model state
  logic         m_bits[$];
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_overrun;
  logic         m_par_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input logic b, input logic sv, input logic rdy, input logic r);
    logic         done;
    logic [W-1:0] word;
    logic         par;
    if (r) begin
      m_bits.delete();
      m_dout    = '0;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      m_par_err = 1'b0;
      return;
    end
    done = 1'b0;
    word = '0;
    par  = 1'b0;
    if (sv) begin
      m_bits.push_back(b);
      if (m_bits.size() == FL) begin
        for (int i = 0; i < W; i++) word = (word << 1) | W'(m_bits[i]);
        for (int i = 0; i < FL; i++) par = par ^ m_bits[i];
        m_bits.delete();
        done = 1'b1;
      end
    end
    m_overrun = 1'b0;
    if (done) begin
      if (m_valid && !rdy) m_overrun = 1'b1;
      else begin
        m_dout    = word;
        m_valid   = 1'b1;
        m_par_err = par;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(input logic b, input logic sv, input logic rdy, input logic r);
    bus.sin        = b;
    bus.sin_valid  = sv;
    bus.dout_ready = rdy;
    rst            = r;
    @(posedge clk_sys);
    model_edge(b, sv, rdy, r);
    #1;
    check("dout", 32'(bus.dout), 32'(m_dout));
    check("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
    check("overrun", 32'(bus.overrun), 32'(m_overrun));
`ifdef SIPO_PARITY_EN
    check("par_err", 32'(bus.par_err), 32'(m_par_err));
`endif
  endtask

  // Sends one frame; the parity bit (if enabled) is even unless bad_par is set.
  task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic rdy_last,
                           input logic bad_par);
    for (int i = W - 1; i >= 0; i--)
      cycle(w[i], 1'b1, (i == 0 && FL == W) ? rdy_last : rdy, 1'b0);
`ifdef SIPO_PARITY_EN
    cycle((^w) ^ bad_par, 1'b1, rdy_last, 1'b0);
`endif
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, rdy, 1'b0);
  endtask

  logic         saw_ov;
  logic [W-1:0] rw;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.sin = 1'b0; bus.sin_valid = 1'b1; bus.dout_ready = 1'b0; rst = 1'b1;

    // reset held two cycles with data offered
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_valid", 32'(bus.dout_valid), 32'h0);

    // simple word with consumer ready
    send_word(4'b1101, 1'b1, 1'b1, 1'b0);
    check("t2_dout", 32'(bus.dout), 32'hD);
    check("t2_valid", 32'(bus.dout_valid), 32'h1);
    idle(1'b1);
    check("t2_consumed", 32'(bus.dout_valid), 32'h0);

    // gap of 3 cycles after bit 2
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    check("t3_no_word", 32'(bus.dout_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
`endif
    check("t3_dout", 32'(bus.dout), 32'hD);
    idle(1'b1);
    check("t3_single", 32'(bus.dout_valid), 32'h0);

    // overrun while holding register is full
    send_word(4'b1101, 1'b0, 1'b0, 1'b0);
    saw_ov = bus.overrun;
    send_word(4'b0110, 1'b0, 1'b0, 1'b0);
    check("t4_ov_pulse", 32'(bus.overrun), 32'h1);
    check("t4_dout_kept", 32'(bus.dout), 32'hD);
    idle(1'b0);
    check("t4_ov_one_cycle", 32'(bus.overrun), 32'h0);
    idle(1'b1);
    check("t4_drained", 32'(bus.dout_valid), 32'h0);
    check("t4_no_early_ov", 32'(saw_ov), 32'h0);

    // consume and refill on the same edge
    send_word(4'b1010, 1'b0, 1'b0, 1'b0);
    send_word(4'b0011, 1'b0, 1'b1, 1'b0);
    check("t5_dout", 32'(bus.dout), 32'h3);
    check("t5_valid", 32'(bus.dout_valid), 32'h1);
    check("t5_no_ov", 32'(bus.overrun), 32'h0);
    idle(1'b1);

    // reset mid-word discards the partial bits
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    send_word(4'b1001, 1'b1, 1'b1, 1'b0);
    check("t6_dout", 32'(bus.dout), 32'h9);
    check("t6_valid", 32'(bus.dout_valid), 32'h1);
`ifdef SIPO_PARITY_EN
    idle(1'b1);
    send_word(4'b1101, 1'b1, 1'b1, 1'b0);
    check("t6_par_ok", 32'(bus.par_err), 32'h0);
    send_word(4'b1101, 1'b1, 1'b1, 1'b1);
    check("t6_par_bad", 32'(bus.par_err), 32'h1);
    check("t6_par_word", 32'(bus.dout), 32'hD);
`endif

    // back-to-back frames with a random consumer and occasional reset
    for (int n = 0; n < 200; n++) begin
      rw = W'($urandom);
      send_word(rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0));
    end
    for (int n = 0; n < 2000; n++) begin
      cycle(1'($urandom), $urandom_range(0, 9) < 7, 1'($urandom),
            $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
